// File: rtl/pbs_pkg.sv
// -----------------------------------------------------------------------------
// pbs_pkg
// Shared definitions for the battle-game attack resolver:
//   - stat and move widths
//   - move damage/accuracy table and lookup helpers
//   - resolver FSM state encoding
//   - default LFSR seed
// -----------------------------------------------------------------------------
package pbs_pkg;

  localparam int unsigned STAT_W = 4;
  localparam int unsigned MOVE_W = 2;

  localparam logic [15:0] PBS_DEFAULT_SEED = 16'hACE1;

  // Move table: damage / accuracy per move index.
  localparam logic [STAT_W-1:0] MOVE0_DMG  = 4'd2;
  localparam logic [STAT_W-1:0] MOVE0_ACCU = 4'd15;
  localparam logic [STAT_W-1:0] MOVE1_DMG  = 4'd4;
  localparam logic [STAT_W-1:0] MOVE1_ACCU = 4'd12;
  localparam logic [STAT_W-1:0] MOVE2_DMG  = 4'd6;
  localparam logic [STAT_W-1:0] MOVE2_ACCU = 4'd8;
  localparam logic [STAT_W-1:0] MOVE3_DMG  = 4'd9;
  localparam logic [STAT_W-1:0] MOVE3_ACCU = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_ROLL = 2'd2,
    ST_DONE = 2'd3
  } res_state_e;

  function automatic logic [STAT_W-1:0] move_dmg(input logic [MOVE_W-1:0] mv);
    logic [STAT_W-1:0] d;
    case (mv)
      2'd0:    d = MOVE0_DMG;
      2'd1:    d = MOVE1_DMG;
      2'd2:    d = MOVE2_DMG;
      2'd3:    d = MOVE3_DMG;
      default: d = MOVE0_DMG;
    endcase
    return d;
  endfunction

  function automatic logic [STAT_W-1:0] move_accu(input logic [MOVE_W-1:0] mv);
    logic [STAT_W-1:0] a;
    case (mv)
      2'd0:    a = MOVE0_ACCU;
      2'd1:    a = MOVE1_ACCU;
      2'd2:    a = MOVE2_ACCU;
      2'd3:    a = MOVE3_ACCU;
      default: a = MOVE0_ACCU;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/move_resolver_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1,
// shifting left every cycle with the feedback bit entering at bit 0.
// A SEED of zero would lock the register at zero, so it is replaced by the
// package default seed.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset (loads the seed)
//   state_o out  current 16-bit LFSR state
// -----------------------------------------------------------------------------
module lfsr16
  import pbs_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state_o
);

  localparam logic [15:0] LOAD_VAL = (SEED == 16'h0000) ? PBS_DEFAULT_SEED : SEED;

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        fb_s;

  // Next-state: taps at bits 16/14/13/11 (1-based) map to 15/13/12/10.
  always_comb begin
    fb_s    = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
    state_d = {state_q[14:0], fb_s};
  end

  // State register with synchronous seed load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/move_resolver.sv
// -----------------------------------------------------------------------------
// move_resolver
// Resolves one attack per start pulse: selects the player move (target=0)
// or a pseudo-random AI move (target=1), rolls accuracy against the LFSR (or
// a forced debug roll) and reports hit/miss plus the damage to apply.
// Also provides a combinational damage/accuracy preview of p_move.
//
// Build option: define PBS_CRIT_EN to enable critical hits (roll==0 on a hit
// deals double damage, saturating at the STAT_W maximum).
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   start        in   resolve request, only looked at in IDLE
//   target       in   0: player attacks (p_move), 1: AI attacks (random move)
//   p_move       in   player move select
//   dbg_roll_en  in   use dbg_roll instead of the LFSR roll
//   dbg_roll     in   forced roll value
//   busy         out  high in SEL and ROLL
//   done         out  one-cycle result strobe (DONE state)
//   hit          out  last attack hit
//   dmg_out      out  damage to apply, 0 on a miss
//   ai_move      out  move used by the last AI attack
//   disp_dmg     out  damage of p_move (combinational)
//   disp_accu    out  accuracy of p_move (combinational)
// -----------------------------------------------------------------------------
module move_resolver #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int unsigned STAT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              target,
  input  logic [1:0]        p_move,
  input  logic              dbg_roll_en,
  input  logic [STAT_W-1:0] dbg_roll,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [STAT_W-1:0] dmg_out,
  output logic [1:0]        ai_move,
  output logic [STAT_W-1:0] disp_dmg,
  output logic [STAT_W-1:0] disp_accu
);

  import pbs_pkg::*;

  res_state_e        state_q, state_d;
  logic [1:0]        move_q, move_d;
  logic [1:0]        ai_move_q, ai_move_d;
  logic              hit_q, hit_d;
  logic [STAT_W-1:0] dmg_q, dmg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [15:0]       lfsr_s;
  logic [1:0]        sel_move_s;
  logic [STAT_W-1:0] roll_s;
  logic [STAT_W-1:0] accu_s;
  logic [STAT_W-1:0] base_dmg_s;
  logic [STAT_W-1:0] hit_dmg_s;
  logic              hit_s;
  logic              unused_lfsr_s;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr_s)
  );

  // Only the move and roll bits of the LFSR are consumed.
  assign unused_lfsr_s = ^lfsr_s[15:6];

  // Preview for the display decoders: pure lookup, no state involved.
  assign disp_dmg  = STAT_W'(move_dmg(p_move));
  assign disp_accu = STAT_W'(move_accu(p_move));

  assign sel_move_s = target ? lfsr_s[5:4] : p_move;
  assign roll_s     = dbg_roll_en ? dbg_roll : lfsr_s[STAT_W-1:0];
  assign accu_s     = STAT_W'(move_accu(move_q));
  assign base_dmg_s = STAT_W'(move_dmg(move_q));
  assign hit_s      = (roll_s < accu_s);

`ifdef PBS_CRIT_EN
  logic [STAT_W:0] dbl_dmg_s;

  // A zero roll is a critical: doubled damage, clamped to the largest stat.
  assign dbl_dmg_s = {base_dmg_s, 1'b0};
  assign hit_dmg_s = (roll_s != {STAT_W{1'b0}}) ? base_dmg_s :
                     (dbl_dmg_s[STAT_W] ? {STAT_W{1'b1}} : dbl_dmg_s[STAT_W-1:0]);
`else
  assign hit_dmg_s = base_dmg_s;
`endif

  // Next-state and result computation for the resolver FSM.
  always_comb begin
    state_d   = state_q;
    move_d    = move_q;
    ai_move_d = ai_move_q;
    hit_d     = hit_q;
    dmg_d     = dmg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEL: begin
        state_d = ST_ROLL;
        move_d  = sel_move_s;
        if (target) begin
          ai_move_d = sel_move_s;
        end else begin
          ai_move_d = ai_move_q;
        end
      end
      ST_ROLL: begin
        state_d = ST_DONE;
        hit_d   = hit_s;
        if (hit_s) begin
          dmg_d = hit_dmg_s;
        end else begin
          dmg_d = {STAT_W{1'b0}};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Handshake flags are registered from the next state so they are Moore.
    busy_d = (state_d == ST_SEL) || (state_d == ST_ROLL);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset discards any attack in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      move_q    <= 2'd0;
      ai_move_q <= 2'd0;
      hit_q     <= 1'b0;
      dmg_q     <= {STAT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      move_q    <= move_d;
      ai_move_q <= ai_move_d;
      hit_q     <= hit_d;
      dmg_q     <= dmg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hit     = hit_q;
  assign dmg_out = dmg_q;
  assign ai_move = ai_move_q;

endmodule

// File: doc/move_resolver.md
Name: move_resolver

Overview:
Resolves one attack per turn for the battle game.
- Sits between the control FSM and the battle datapath.
- On a start pulse from control, selects the attacking move:
  - player move from the switches, or
  - a pseudo-random AI move.
- Rolls accuracy against a free-running LFSR and outputs hit/miss plus the damage to apply.
- Also drives the combinational damage/accuracy preview of the selected player move, which feeds the two-digit decimal display decoders.

Parameters:
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.
- STAT_W, 4, width of damage, accuracy and roll values.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- start  in  1  request to resolve one attack; sampled only in IDLE
- target  in  1  0 = player attacks AI (move from p_move); 1 = AI attacks player (random move)
- p_move  in  2  player move select (switches)
- dbg_roll_en  in  1  when 1, dbg_roll replaces the LFSR roll (test hook)
- dbg_roll  in  STAT_W  forced roll value
- busy  out  1  resolution in progress
- done  out  1  one-cycle result-valid strobe
- hit  out  1  last attack hit
- dmg_out  out  STAT_W  damage to apply; 0 on a miss
- ai_move  out  2  move used by the last AI attack
- disp_dmg  out  STAT_W  damage of p_move (combinational)
- disp_accu  out  STAT_W  accuracy of p_move (combinational)

Behaviour:
- Move table (damage/accuracy):
  - move 0: 2/15
  - move 1: 4/12
  - move 2: 6/8
  - move 3: 9/5
- Outputs disp_dmg/disp_accu are a pure table lookup of p_move, independent of state.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left every cycle. Reset loads SEED and never reaches the all-zero state.
- Roll source: roll = dbg_roll_en ? dbg_roll : lfsr[3:0].
- Hit rule: hit = (roll < accu), unsigned compare.
- FSM states: IDLE, SEL, ROLL, DONE.
  - IDLE -> SEL when start=1. Otherwise stays in IDLE.
  - SEL -> ROLL unconditionally.
    - Latches the move: p_move if target=0, else lfsr[5:4].
    - When target=1, ai_move is updated with that move; it holds otherwise.
  - ROLL -> DONE unconditionally. Samples the roll and registers hit and dmg_out (damage if hit, else 0).
  - DONE -> IDLE unconditionally.
- Handshake and latency:
  - busy = 1 in SEL and ROLL only.
  - done = 1 in DONE only (Moore).
  - start sampled at edge k gives done high in the cycle following edge k+2, i.e. 3 cycles from start to done.
- start is ignored in SEL, ROLL and DONE. It is not queued; control must re-pulse it after done.
- hit, dmg_out and ai_move hold their values from DONE until the next ROLL/SEL overwrites them.
- Inputs target and p_move are sampled in SEL only; changes after SEL do not affect the result in flight.
- Reset values: state IDLE, lfsr=SEED, busy=0, done=0, hit=0, dmg_out=0, ai_move=0.
- rst asserted in any state returns to IDLE at the next edge with the reset values above; any in-flight result is discarded and no done is issued.

Optional Feature:
- Macro: PBS_CRIT_EN.
- Defined: a hit with roll==0 is critical and deals double damage, saturating at 15 (e.g. move 3 gives 15, not 18).
- Undefined: no critical logic is built; damage on a hit is always the table value.

Decomposition:
- Shared package pbs_pkg holds:
  - STAT_W and MOVE_W = 2
  - the move damage/accuracy table constants
  - the resolver state enum
  - the default LFSR seed
- One sub-module: lfsr16 (SEED parameter; clk/rst; 16-bit state output).

Test Plan:
- Reset with SEED=16'hACE1, idle 5 cycles -> busy=0, done=0, hit=0, dmg_out=0; the LFSR sequence matches a reference model.
- target=0, p_move=2, dbg_roll_en=1, dbg_roll=7, start pulse -> done exactly 3 cycles later for 1 cycle, hit=1, dmg_out=6. Repeat with dbg_roll=8 -> hit=0, dmg_out=0.
- p_move sweep 0..3 -> disp_dmg/disp_accu = 2/15, 4/12, 6/8, 9/5 with no clock required.
- target=1, dbg_roll_en=0, 100 back-to-back attacks -> ai_move matches lfsr[5:4] sampled in SEL; all four moves occur; start pulses during busy/done are ignored.
- rst asserted in ROLL -> next cycle IDLE, no done pulse, dmg_out=0; a following start resolves normally.
- With PBS_CRIT_EN: p_move=1, roll 0 -> dmg_out=8; p_move=3, roll 0 -> dmg_out=15. Without PBS_CRIT_EN, the same stimulus gives 4 and 9.
